// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the I/D Wishbone sequencing arbiter.
package rv_wb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    localparam logic [WB_SW-1:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // Request payload latched at grant and held for the whole bus cycle.
    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic             we;
        logic [WB_SW-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/rv_wb_watchdog.sv
// Bus-cycle watchdog: counts cycles while a cycle is in flight and flags
// expiry at count TIMEOUT-1 unless ack arrives on that same cycle.
module rv_wb_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (i_run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = i_run && !i_ack && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rv_wb_arbiter.sv
// Shares one classic Wishbone master port between fetch (I) and load/store (D),
// round-robin on ties. Define RV_WB_TIMEOUT_EN to build the ack watchdog.
module rv_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_i_req,
    input  logic [WB_AW-1:0] i_i_adr,
    output logic             o_i_ack,
    output logic             o_i_err,
    output logic [WB_DW-1:0] o_i_dat,
    input  logic             i_d_req,
    input  logic [WB_AW-1:0] i_d_adr,
    input  logic [WB_DW-1:0] i_d_dat,
    input  logic             i_d_we,
    input  logic [WB_SW-1:0] i_d_sel,
    output logic             o_d_ack,
    output logic             o_d_err,
    output logic [WB_DW-1:0] o_d_dat,
    output logic [WB_AW-1:0] o_wb_adr,
    output logic [WB_DW-1:0] o_wb_dat,
    output logic             o_wb_we,
    output logic [WB_SW-1:0] o_wb_sel,
    output logic             o_wb_stb,
    output logic             o_wb_cyc,
    input  logic [WB_DW-1:0] i_wb_dat,
    input  logic             i_wb_ack
);

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("rv_wb_arbiter: TIMEOUT must be in 2..255");
    end

    state_e  state_q, state_d;
    grant_e  last_q, last_d;
    wb_req_t req_q, req_d;
    logic    expire;
    logic    ack_ok;

    // Reset abandons the cycle, so an ack arriving in the reset cycle is dropped.
    assign ack_ok = i_wb_ack && !i_reset;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (i_d_req && (!i_i_req || (last_q == GNT_I))) begin
                    state_d = BUS_D;
                    last_d  = GNT_D;
                    req_d   = '{adr: i_d_adr, dat: i_d_dat, we: i_d_we, sel: i_d_sel};
                end else if (i_i_req) begin
                    state_d = BUS_I;
                    last_d  = GNT_I;
                    req_d   = '{adr: i_i_adr, dat: '0, we: 1'b0, sel: WB_SEL_ALL};
                end
            end
            BUS_I, BUS_D: begin
                if (i_wb_ack || expire) begin
                    state_d  = IDLE;
                    req_d.we = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= GNT_I;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
        end
    end

    assign o_wb_cyc = (state_q != IDLE);
    assign o_wb_stb = (state_q != IDLE);
    assign o_wb_adr = req_q.adr;
    assign o_wb_dat = req_q.dat;
    assign o_wb_we  = req_q.we;
    assign o_wb_sel = req_q.sel;

    assign o_i_ack = (state_q == BUS_I) && ack_ok;
    assign o_d_ack = (state_q == BUS_D) && ack_ok;
    assign o_i_dat = o_i_ack ? i_wb_dat : '0;
    assign o_d_dat = o_d_ack ? i_wb_dat : '0;

`ifdef RV_WB_TIMEOUT_EN
    rv_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_run    (state_q != IDLE),
        .i_ack    (i_wb_ack),
        .o_expire (expire)
    );

    assign o_i_err = (state_q == BUS_I) && expire && !i_reset;
    assign o_d_err = (state_q == BUS_D) && expire && !i_reset;
`else
    assign expire  = 1'b0;
    assign o_i_err = 1'b0;
    assign o_d_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Scoreboard bench for rv_wb_arbiter; watchdog cases follow RV_WB_TIMEOUT_EN.
module tb_rv_wb_arbiter;

    localparam int unsigned TO = 16;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          len;
        int          gap;
    } bus_t;

    typedef struct {
        logic        own_d;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_i_req = 1'b0;
    logic [31:0] i_i_adr = '0;
    logic        o_i_ack, o_i_err;
    logic [31:0] o_i_dat;
    logic        i_d_req = 1'b0;
    logic [31:0] i_d_adr = '0;
    logic [31:0] i_d_dat = '0;
    logic        i_d_we = 1'b0;
    logic [3:0]  i_d_sel = '0;
    logic        o_d_ack, o_d_err;
    logic [31:0] o_d_dat;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic        o_wb_we, o_wb_stb, o_wb_cyc;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bus_t  bq[$];
    resp_t rq[$];
    bus_t  cur;
    logic  cyc_prev = 1'b0;
    int    len_n = 0;
    int    idle_n = 0;
    logic  i_done = 1'b0;
    logic  d_done = 1'b0;

    logic  slave_en = 1'b1;
    int    slave_wait = 0;
    int    scnt = 0;
    logic  f_ack = 1'b0;

    always #5 clk = ~clk;

    rv_wb_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_i_req  (i_i_req),
        .i_i_adr  (i_i_adr),
        .o_i_ack  (o_i_ack),
        .o_i_err  (o_i_err),
        .o_i_dat  (o_i_dat),
        .i_d_req  (i_d_req),
        .i_d_adr  (i_d_adr),
        .i_d_dat  (i_d_dat),
        .i_d_we   (i_d_we),
        .i_d_sel  (i_d_sel),
        .o_d_ack  (o_d_ack),
        .o_d_err  (o_d_err),
        .o_d_dat  (o_d_dat),
        .o_wb_adr (o_wb_adr),
        .o_wb_dat (o_wb_dat),
        .o_wb_we  (o_wb_we),
        .o_wb_sel (o_wb_sel),
        .o_wb_stb (o_wb_stb),
        .o_wb_cyc (o_wb_cyc),
        .i_wb_dat (i_wb_dat),
        .i_wb_ack (i_wb_ack)
    );

    function automatic logic [31:0] rdat(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Slave and requester model: reacts just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (i_done) i_i_req = 1'b0;
            if (d_done) i_d_req = 1'b0;
            scnt = o_wb_cyc ? scnt + 1 : 0;
            i_wb_ack = f_ack || (slave_en && o_wb_cyc && (scnt == slave_wait + 1));
            i_wb_dat = i_wb_ack ? rdat(o_wb_adr) : 32'h0;
        end
    end

    // Monitor: checks bus cycles against bq and requester responses against rq.
    always @(negedge clk) begin
        resp_t r;
        i_done = o_i_ack | o_i_err;
        d_done = o_d_ack | o_d_err;
        if (o_i_ack | o_i_err | o_d_ack | o_d_err) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", {o_i_ack, o_i_err, o_d_ack, o_d_err}, 32'h0);
            end else begin
                r = rq.pop_front();
                chk("resp_flags", {o_i_ack, o_i_err, o_d_ack, o_d_err},
                    {r.own_d ? 1'b0 : !r.err, r.own_d ? 1'b0 : r.err,
                     r.own_d ? !r.err : 1'b0, r.own_d ? r.err : 1'b0});
                chk("resp_i_dat", o_i_dat, (!r.own_d && !r.err) ? r.dat : 32'h0);
                chk("resp_d_dat", o_d_dat, (r.own_d && !r.err) ? r.dat : 32'h0);
            end
        end
        if (o_wb_cyc && !cyc_prev) begin
            if (bq.size() == 0) begin
                chk("unexpected_bus_cycle", o_wb_adr, 32'hFFFF_FFFF);
                cur = '{adr: o_wb_adr, dat: o_wb_dat, we: o_wb_we, sel: o_wb_sel, len: -1, gap: -1};
            end else begin
                cur = bq.pop_front();
                if (cur.gap >= 0) chk("idle_gap", idle_n, cur.gap);
                chk("bus_we", o_wb_we, cur.we);
                chk("bus_sel", o_wb_sel, cur.sel);
                chk("bus_dat", o_wb_dat, cur.dat);
            end
            len_n = 0;
        end
        if (o_wb_cyc) begin
            len_n++;
            chk("bus_adr", o_wb_adr, cur.adr);
            chk("bus_stb", o_wb_stb, 1'b1);
            idle_n = 0;
        end else begin
            if (cyc_prev && cur.len >= 0) chk("cyc_len", len_n, cur.len);
            idle_n++;
        end
        cyc_prev = o_wb_cyc;
    end

    task automatic exp_i(input logic [31:0] a, input int len, input int gap);
        bq.push_back('{adr: a, dat: 32'h0, we: 1'b0, sel: 4'hF, len: len, gap: gap});
        rq.push_back('{own_d: 1'b0, err: 1'b0, dat: rdat(a)});
    endtask

    task automatic exp_d(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic [3:0] sel, input int len, input int gap, input logic err);
        bq.push_back('{adr: a, dat: d, we: we, sel: sel, len: len, gap: gap});
        rq.push_back('{own_d: 1'b1, err: err, dat: err ? 32'h0 : rdat(a)});
    endtask

    task automatic drive_d(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
        i_d_adr = a; i_d_dat = d; i_d_we = we; i_d_sel = sel; i_d_req = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (rq.size() == 0 && bq.size() == 0 && !o_wb_cyc && !i_i_req && !i_d_req) return;
        end
        chk({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic reset_pulse();
        @(negedge clk); i_reset = 1'b1;
        @(negedge clk); i_reset = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", o_wb_cyc, 1'b0);
        chk("rst_stb", o_wb_stb, 1'b0);
        chk("rst_we", o_wb_we, 1'b0);
        chk("rst_adr", o_wb_adr, 32'h0);
        chk("rst_dat", o_wb_dat, 32'h0);
        chk("rst_sel", o_wb_sel, 4'h0);
        chk("rst_resp", {o_i_ack, o_i_err, o_d_ack, o_d_err}, 4'h0);
        i_reset = 1'b0;

        // Single fetch, 2-wait slave
        @(negedge clk);
        slave_wait = 2;
        exp_i(32'h0000_0100, 3, -1);
        i_i_adr = 32'h0000_0100; i_i_req = 1'b1;
        @(negedge clk);
        chk("fetch_start_cyc", o_wb_cyc, 1'b1);
        wait_idle("fetch", 30);

        // Store, zero-wait slave
        slave_wait = 0;
        exp_d(32'h2000_0004, 32'hDEAD_BEEF, 1'b1, 4'b0011, 1, -1, 1'b0);
        drive_d(32'h2000_0004, 32'hDEAD_BEEF, 1'b1, 4'b0011);
        @(negedge clk);
        chk("store_start_cyc", o_wb_cyc, 1'b1);
        chk("store_no_i_ack", o_i_ack, 1'b0);
        wait_idle("store", 30);

        // Tie straight after reset: D first, then I after one idle cycle
        reset_pulse();
        exp_d(32'h0000_0400, 32'h1111_2222, 1'b0, 4'hF, 1, -1, 1'b0);
        exp_i(32'h0000_0300, 1, 1);
        drive_d(32'h0000_0400, 32'h1111_2222, 1'b0, 4'hF);
        i_i_adr = 32'h0000_0300; i_i_req = 1'b1;
        wait_idle("tie1", 40);

        // Lone D, then a tie must go to I, then D
        exp_d(32'h0000_0500, 32'h3333_4444, 1'b1, 4'b1100, 1, -1, 1'b0);
        drive_d(32'h0000_0500, 32'h3333_4444, 1'b1, 4'b1100);
        wait_idle("lone_d", 30);
        exp_i(32'h0000_0600, 1, -1);
        exp_d(32'h0000_0700, 32'h5555_6666, 1'b1, 4'b0001, 1, 1, 1'b0);
        i_i_adr = 32'h0000_0600; i_i_req = 1'b1;
        drive_d(32'h0000_0700, 32'h5555_6666, 1'b1, 4'b0001);
        wait_idle("tie2", 40);

        // Reset during BUS_D with ack withheld, then a stray ack in IDLE
        slave_en = 1'b0;
        bq.push_back('{adr: 32'h0000_0800, dat: 32'h7777_8888, we: 1'b1, sel: 4'hF, len: 3, gap: -1});
        drive_d(32'h0000_0800, 32'h7777_8888, 1'b1, 4'hF);
        repeat (3) @(negedge clk);
        i_reset = 1'b1; i_d_req = 1'b0;
        @(negedge clk);
        chk("midrst_cyc", o_wb_cyc, 1'b0);
        chk("midrst_stb", o_wb_stb, 1'b0);
        chk("midrst_we", o_wb_we, 1'b0);
        i_reset = 1'b0;
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        chk("idle_ack_driven", i_wb_ack, 1'b1);
        chk("idle_ack_ignored", {o_i_ack, o_d_ack}, 2'b00);
        @(negedge clk);
        chk("idle_ack_no_cyc", o_wb_cyc, 1'b0);
        slave_en = 1'b1;

`ifdef RV_WB_TIMEOUT_EN
        // Silent slave: err on the TO-th cycle of cyc, cyc low after
        slave_en = 1'b0;
        exp_d(32'h0000_0900, 32'h0, 1'b0, 4'hF, TO, -1, 1'b1);
        drive_d(32'h0000_0900, 32'h0, 1'b0, 4'hF);
        wait_idle("watchdog", TO + 20);
        // Ack on the expiry cycle wins over err
        slave_en = 1'b1;
        slave_wait = TO - 1;
        exp_d(32'h0000_0A00, 32'h0, 1'b0, 4'hF, TO, -1, 1'b0);
        drive_d(32'h0000_0A00, 32'h0, 1'b0, 4'hF);
        wait_idle("ack_at_expiry", TO + 20);
`else
        // No watchdog: cycle waits indefinitely without err
        slave_en = 1'b0;
        bq.push_back('{adr: 32'h0000_0900, dat: 32'h0, we: 1'b0, sel: 4'hF, len: -1, gap: -1});
        drive_d(32'h0000_0900, 32'h0, 1'b0, 4'hF);
        repeat (120) @(negedge clk);
        chk("nowd_cyc_held", o_wb_cyc, 1'b1);
        chk("nowd_no_err", {o_i_err, o_d_err}, 2'b00);
        rq.push_back('{own_d: 1'b1, err: 1'b0, dat: rdat(32'h0000_0900)});
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        wait_idle("nowd_release", 20);
        slave_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", rq.size(), 32'h0);
        chk("bus_queue_empty", bq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
